gpi_pad_rx_ctrl: RTL and testbench
==================================

// Module: gpi_pad_rx_ctrl
// PURPOSE
//  Receive-side controller for a general-purpose IO pad, the input counterpart of the GPO driver path.
//  - Drives the pad input enable and pull controls.
//  - Synchronises the raw pad data into CLK_I and removes glitches with a debounce filter.
//  - Detects edges and raises a sticky interrupt.
//  - Sits between the IO ring cell and the core GPIO register block.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on the pad data path; legal range 2..4
//  DEB_W        8  debounce counter width; maximum filter length is 2**DEB_W-1 cycles
// PORTS
//  CLK_I        in   1      core clock
//  RSTN_I       in   1      asynchronous, active-low reset
//  PAD_DI_I     in   1      raw data from the pad cell; asynchronous, undefined while IE_O=0
//  IE_O         out  1      pad input enable (registered)
//  PE_O         out  1      pad pull enable (registered)
//  PS_O         out  1      pad pull select, 1=up 0=down (registered)
//  cfg_ie_i     in   1      requested input enable
//  cfg_pe_i     in   1      requested pull enable
//  cfg_ps_i     in   1      requested pull select
//  deb_len_i    in   DEB_W  stable cycles required before accepting a new level; 0 = no filtering
//  irq_mode_i   in   2      00 off, 01 rising, 10 falling, 11 both edges
//  irq_clr_i    in   1      one-cycle pulse that clears the pending interrupt
//  data_o       out  1      filtered pad level
//  rise_o       out  1      one-cycle pulse on a filtered 0->1 transition
//  fall_o       out  1      one-cycle pulse on a filtered 1->0 transition
//  irq_o        out  1      sticky interrupt pending
// BEHAVIOUR
//  Reset: all outputs 0; sync chain, debounce counter and FSM return to STABLE with level 0.
//  Pad control: IE_O/PE_O/PS_O = cfg_*_i delayed by 1 cycle.
//  Sync input: sync input = PAD_DI_I & IE_O, so a disabled pad reads 0 and X never propagates.
//  Sync chain: SYNC_STAGES flops produce sync_q.
//  FSM STABLE: if sync_q==data_o, stay; otherwise load cnt=1.
//   - If deb_len_i<=1, update data_o on that same edge and stay in STABLE.
//   - Otherwise go to FILTER.
//  FSM FILTER:
//   - sync_q==data_o: cnt<=0, go to STABLE (glitch rejected).
//   - else if cnt==deb_len_i-1: data_o<=sync_q, cnt<=0, go to STABLE.
//   - else cnt<=cnt+1.
//  Latency: pad edge to data_o = SYNC_STAGES + max(deb_len_i,1) cycles.
//   - Example: SYNC_STAGES=2, deb_len=4 -> 6 cycles.
//  Pulse width: a pad pulse shorter than deb_len_i synced cycles never reaches data_o.
//  deb_len_i change mid-FILTER: takes effect immediately.
//   - If cnt >= new deb_len_i-1, the accept happens on the next edge where the compare is evaluated; no counter wrap is allowed.
//  Edges: rise_o/fall_o are asserted the cycle after data_o changes, for exactly 1 cycle.
//  Interrupt set condition: (rise & mode[0]) | (fall & mode[1]).
//  Interrupt clear: irq_clr_i clears irq_o.
//  Simultaneous set and clear in one cycle: set wins, so no event is lost.
//  irq_mode_i change: never clears irq_o. Mode 00 blocks new sets only.
//  cfg_ie_i dropping while data_o=1: the input is forced 0, which yields a normal filtered fall.
// CONFIGURATION
//  Macro: GPI_RX_DEBOUNCE_EN
//  Defined: debounce FSM and counter present exactly as specified above.
//  Undefined: counter and FSM removed.
//   - data_o <= sync_q every cycle, so latency = SYNC_STAGES+1.
//   - deb_len_i is ignored; the port remains for a stable interface.
//   - Edge and interrupt logic are unchanged.
// STRUCTURE
//  Package gpi_rx_pkg:
//   - irq_mode_e enum (IRQ_OFF, IRQ_RISE, IRQ_FALL, IRQ_BOTH)
//   - deb_state_e enum (STABLE, FILTER)
//   - default constants SYNC_STAGES_DEF=2, DEB_W_DEF=8
//  Sub-module gpi_rx_sync:
//   - parameterised SYNC_STAGES flop chain with async active-low reset to 0.
//   - Instantiated once; the CDC tool constraint is attached here.
//  Top level holds the pad-control registers, debounce FSM, edge detection and irq flag.
// TESTING
//  1. Reset with PAD_DI_I=1 and cfg_ie_i=0: data_o, irq_o and IE_O are 0; data_o stays 0 because the input is masked.
//  2. cfg_ie_i=1, deb_len=4, pad 0->1 held: data_o rises 6 cycles later; rise_o is one pulse; irq_o=1 in mode 01.
//  3. deb_len=4, pad high for 3 synced cycles then low: data_o stays 0, no rise_o, FSM back in STABLE.
//  4. Mode 11, irq already pending, new edge in the same cycle as irq_clr_i: irq_o stays 1; a lone clear next cycle gives irq_o=0.
//  5. deb_len=0 and deb_len=1: the edge reaches data_o SYNC_STAGES+1 cycles after the pad edge.
//  6. Build without GPI_RX_DEBOUNCE_EN, 1-cycle synced glitch: data_o follows with a 1-cycle pulse, rise_o and fall_o each pulse once.

Source files
------------

// File: rtl/gpi_rx_pkg.sv
// -----------------------------------------------------------------------------
// gpi_rx_pkg
// Shared types and default parameter values for the GPIO pad receive path.
//   irq_mode_e  : interrupt edge selection (off / rising / falling / both)
//   deb_state_e : debounce filter state (STABLE / FILTER)
//   SYNC_STAGES_DEF, DEB_W_DEF : default synchroniser depth and counter width
// -----------------------------------------------------------------------------
package gpi_rx_pkg;

    typedef enum logic [1:0] {
        IRQ_OFF  = 2'b00,
        IRQ_RISE = 2'b01,
        IRQ_FALL = 2'b10,
        IRQ_BOTH = 2'b11
    } irq_mode_e;

    typedef enum logic {
        STABLE = 1'b0,
        FILTER = 1'b1
    } deb_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_W_DEF       = 8;

endpackage

// File: rtl/gpi_rx_sync.sv
// -----------------------------------------------------------------------------
// gpi_rx_sync
// Multi-flop synchroniser that brings the asynchronous pad level into the
// core clock domain. This is the single crossing point of the receive path,
// so CDC constraints are attached to this module.
//   clk_i    : destination clock
//   rst_n_i  : asynchronous active-low reset, chain clears to 0
//   d_i      : asynchronous input level
//   q_o      : synchronised level, SYNC_STAGES cycles later
// SYNC_STAGES legal range is 2..4.
// -----------------------------------------------------------------------------
module gpi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpi_pad_rx_ctrl.sv
// -----------------------------------------------------------------------------
// gpi_pad_rx_ctrl
// Receive-side controller for a general-purpose IO pad. Registers the pad
// input-enable / pull controls, synchronises and debounces the pad level,
// produces one-cycle edge pulses and a sticky interrupt flag.
//
// Ports
//   CLK_I, RSTN_I          : core clock, asynchronous active-low reset
//   PAD_DI_I               : raw asynchronous pad data
//   IE_O / PE_O / PS_O     : registered pad input enable, pull enable, pull select
//   cfg_ie_i/pe_i/ps_i     : requested pad controls
//   deb_len_i              : stable cycles needed before a new level is accepted
//   irq_mode_i             : 00 off, 01 rising, 10 falling, 11 both
//   irq_clr_i              : clears the pending interrupt (a set in the same
//                            cycle wins)
//   data_o                 : filtered pad level
//   rise_o / fall_o        : one-cycle pulses, one cycle after data_o changes
//   irq_o                  : sticky interrupt pending
//
// Build option
//   GPI_RX_DEBOUNCE_EN defined   : debounce FSM and counter present.
//   GPI_RX_DEBOUNCE_EN undefined : data_o follows the synchronised level every
//                                  cycle; deb_len_i is accepted but unused.
// -----------------------------------------------------------------------------
module gpi_pad_rx_ctrl
    import gpi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_W       = DEB_W_DEF
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             PAD_DI_I,
    output logic             IE_O,
    output logic             PE_O,
    output logic             PS_O,
    input  logic             cfg_ie_i,
    input  logic             cfg_pe_i,
    input  logic             cfg_ps_i,
    input  logic [DEB_W-1:0] deb_len_i,
    input  logic [1:0]       irq_mode_i,
    input  logic             irq_clr_i,
    output logic             data_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             irq_o
);

    logic      ie_q, pe_q, ps_q;
    logic      sync_in;
    logic      sync_q;
    logic      data_q, data_d;
    logic      data_dly_q;
    logic      rise_q, rise_d;
    logic      fall_q, fall_d;
    logic      irq_q, irq_d;
    logic      irq_set;
    irq_mode_e irq_mode;

    // A disabled pad reads 0, so an undefined pad level never enters the chain.
    assign sync_in = PAD_DI_I & ie_q;

    gpi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (CLK_I),
        .rst_n_i (RSTN_I),
        .d_i     (sync_in),
        .q_o     (sync_q)
    );

`ifdef GPI_RX_DEBOUNCE_EN
    localparam logic [DEB_W-1:0] CNT_ONE = DEB_W'(1);

    deb_state_e       state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             len_reached;

    // cnt >= deb_len-1 evaluated one bit wider, so a length shortened below
    // the running count (or to 0) accepts immediately instead of wrapping.
    assign len_reached = ({1'b0, cnt_q} + {{DEB_W{1'b0}}, 1'b1}) >= {1'b0, deb_len_i};

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= STABLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync_q != data_q) begin
                    cnt_d = CNT_ONE;
                    if (deb_len_i <= CNT_ONE) begin
                        accept = 1'b1;
                    end else begin
                        state_d = FILTER;
                    end
                end
            end
            FILTER: begin
                if (sync_q == data_q) begin
                    // Level returned before the filter expired: glitch dropped.
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (len_reached) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d = accept ? sync_q : data_q;
    end
`else
    logic unused_deb_len;

    assign unused_deb_len = ^deb_len_i;
    assign data_d         = sync_q;
`endif

    assign irq_mode = irq_mode_e'(irq_mode_i);
    assign rise_d   = data_q & ~data_dly_q;
    assign fall_d   = ~data_q & data_dly_q;
    assign irq_set  = (rise_q && (irq_mode inside {IRQ_RISE, IRQ_BOTH}))
                   || (fall_q && (irq_mode inside {IRQ_FALL, IRQ_BOTH}));
    // Set has priority over clear so an event coinciding with a clear is kept.
    assign irq_d    = irq_set | (irq_q & ~irq_clr_i);

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            ie_q       <= 1'b0;
            pe_q       <= 1'b0;
            ps_q       <= 1'b0;
            data_q     <= 1'b0;
            data_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ie_q       <= cfg_ie_i;
            pe_q       <= cfg_pe_i;
            ps_q       <= cfg_ps_i;
            data_q     <= data_d;
            data_dly_q <= data_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            irq_q      <= irq_d;
        end
    end

    assign IE_O   = ie_q;
    assign PE_O   = pe_q;
    assign PS_O   = ps_q;
    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpi_pad_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpi_pad_rx_ctrl
// Self-checking bench for gpi_pad_rx_ctrl. Stimulus pushes the expected edge
// pulse (kind and cycle) into a queue; a monitor on the falling clock edge pops
// and compares whenever rise_o or fall_o is seen. Level, pad-control and
// interrupt values are checked directly by the stimulus process.
// Works for both builds (with and without GPI_RX_DEBOUNCE_EN).
// -----------------------------------------------------------------------------
module tb_gpi_pad_rx_ctrl;

    localparam int SYNC  = 2;
    localparam int DEB_W = 8;

    typedef struct packed {
        logic is_rise;
        int   cyc;
    } ev_t;

    logic             CLK_I = 1'b0;
    logic             RSTN_I;
    logic             PAD_DI_I;
    logic             IE_O, PE_O, PS_O;
    logic             cfg_ie_i, cfg_pe_i, cfg_ps_i;
    logic [DEB_W-1:0] deb_len_i;
    logic [1:0]       irq_mode_i;
    logic             irq_clr_i;
    logic             data_o, rise_o, fall_o, irq_o;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    gpi_pad_rx_ctrl #(
        .SYNC_STAGES (SYNC),
        .DEB_W       (DEB_W)
    ) dut (
        .CLK_I      (CLK_I),
        .RSTN_I     (RSTN_I),
        .PAD_DI_I   (PAD_DI_I),
        .IE_O       (IE_O),
        .PE_O       (PE_O),
        .PS_O       (PS_O),
        .cfg_ie_i   (cfg_ie_i),
        .cfg_pe_i   (cfg_pe_i),
        .cfg_ps_i   (cfg_ps_i),
        .deb_len_i  (deb_len_i),
        .irq_mode_i (irq_mode_i),
        .irq_clr_i  (irq_clr_i),
        .data_o     (data_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .irq_o      (irq_o)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pad-edge-to-data_o latency in cycles.
    function automatic int lat(input int d);
`ifdef GPI_RX_DEBOUNCE_EN
        return SYNC + ((d < 1) ? 1 : d);
`else
        return SYNC + 1;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    // Drive a pad level; data_o is expected to change l edges later and the
    // edge pulse to be visible one edge after that.
    task automatic pad_edge(input logic v, input int l);
        ev_t e;
        e.is_rise = v;
        e.cyc     = cyc + l + 1;
        exp_q.push_back(e);
        PAD_DI_I = v;
    endtask

    // Called right after pad_edge: data_o must hold until edge l, then switch.
    task automatic settle_check(input logic v, input int l);
        tick(l - 1);
        check("data_before_latency", int'(data_o), int'(!v));
        tick(1);
        check("data_at_latency", int'(data_o), int'(v));
    endtask

    // Scoreboard monitor.
    always @(negedge CLK_I) begin
        if (RSTN_I === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc && !(rise_o || fall_o)) begin
                ev_t m;
                m = exp_q.pop_front();
                check("edge_missed", cyc, m.cyc);
            end
            if (rise_o || fall_o) begin
                check("edge_single_kind", int'(rise_o & fall_o), 0);
                check("edge_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("edge_kind_rise", int'(rise_o), int'(e.is_rise));
                    check("edge_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int l;
        int k;
        ev_t e;

        RSTN_I     = 1'b0;
        PAD_DI_I   = 1'b1;
        cfg_ie_i   = 1'b0;
        cfg_pe_i   = 1'b0;
        cfg_ps_i   = 1'b0;
        deb_len_i  = 8'd4;
        irq_mode_i = 2'b00;
        irq_clr_i  = 1'b0;

        // 1. Reset with pad high and input disabled.
        tick(3);
        check("rst_data", int'(data_o), 0);
        check("rst_irq", int'(irq_o), 0);
        check("rst_ie", int'(IE_O), 0);
        check("rst_pe", int'(PE_O), 0);
        check("rst_ps", int'(PS_O), 0);
        check("rst_rise_fall", int'(rise_o | fall_o), 0);
        RSTN_I = 1'b1;
        tick(8);
        check("masked_data", int'(data_o), 0);
        check("masked_ie", int'(IE_O), 0);

        // Pad controls follow cfg with one cycle delay.
        PAD_DI_I = 1'b0;
        cfg_ie_i = 1'b1;
        cfg_pe_i = 1'b1;
        cfg_ps_i = 1'b1;
        check("ie_delay", int'(IE_O), 0);
        tick(1);
        check("ie_set", int'(IE_O), 1);
        check("pe_set", int'(PE_O), 1);
        check("ps_set", int'(PS_O), 1);
        cfg_ps_i = 1'b0;
        tick(1);
        check("ps_clr", int'(PS_O), 0);
        tick(3);

        // 2. deb_len=4 rising edge, mode rising.
        deb_len_i  = 8'd4;
        irq_mode_i = 2'b01;
        l = lat(4);
        pad_edge(1'b1, l);
        settle_check(1'b1, l);
        check("irq_before_rise", int'(irq_o), 0);
        tick(1);
        check("irq_during_rise", int'(irq_o), 0);
        tick(1);
        check("irq_after_rise", int'(irq_o), 1);
        irq_clr_i = 1'b1;
        tick(1);
        irq_clr_i = 1'b0;
        check("irq_cleared", int'(irq_o), 0);
        pad_edge(1'b0, l);
        settle_check(1'b0, l);
        tick(3);
        check("fall_masked_mode01", int'(irq_o), 0);

        // 3. Pad high for 3 synced cycles with deb_len=4.
`ifdef GPI_RX_DEBOUNCE_EN
        PAD_DI_I = 1'b1;
        tick(3);
        PAD_DI_I = 1'b0;
`else
        pad_edge(1'b1, l);
        tick(3);
        pad_edge(1'b0, l);
`endif
        tick(10);
        check("glitch_data", int'(data_o), 0);
        // A full edge afterwards must still take the whole filter length.
        pad_edge(1'b1, l);
        settle_check(1'b1, l);
        tick(3);
        check("irq_after_second_rise", int'(irq_o), 1);

        // 4. Mode 11, pending irq, clear in the same cycle as a new edge.
        irq_mode_i = 2'b11;
        pad_edge(1'b0, l);
        tick(l + 1);
        check("fall_pulse_now", int'(fall_o), 1);
        irq_clr_i = 1'b1;
        tick(1);
        check("set_wins_over_clear", int'(irq_o), 1);
        tick(1);
        check("lone_clear", int'(irq_o), 0);
        irq_clr_i = 1'b0;

        // Mode 00 keeps a pending irq but blocks new sets.
        pad_edge(1'b1, l);
        tick(l + 3);
        check("irq_mode11_rise", int'(irq_o), 1);
        irq_mode_i = 2'b00;
        tick(2);
        check("mode_off_keeps", int'(irq_o), 1);
        irq_clr_i = 1'b1;
        tick(1);
        irq_clr_i = 1'b0;
        check("mode_off_clear", int'(irq_o), 0);
        pad_edge(1'b0, l);
        tick(l + 3);
        check("mode_off_blocks", int'(irq_o), 0);

        // 5. deb_len=1 and deb_len=0: SYNC+1 latency.
        irq_mode_i = 2'b10;
        deb_len_i  = 8'd1;
        pad_edge(1'b1, lat(1));
        settle_check(1'b1, lat(1));
        tick(2);
        deb_len_i = 8'd0;
        pad_edge(1'b0, lat(0));
        settle_check(1'b0, lat(0));
        tick(3);
        check("irq_fall_mode10", int'(irq_o), 1);
        irq_clr_i = 1'b1;
        tick(1);
        irq_clr_i = 1'b0;

        // 6. One-cycle glitch with no filtering passes straight through.
        pad_edge(1'b1, lat(0));
        tick(1);
        pad_edge(1'b0, lat(0));
        tick(8);
        check("short_pulse_end", int'(data_o), 0);

        // deb_len shortened mid-FILTER below the running count.
`ifdef GPI_RX_DEBOUNCE_EN
        deb_len_i = 8'd8;
        pad_edge(1'b1, 6);
        tick(5);
        check("midfilter_hold", int'(data_o), 0);
        deb_len_i = 8'd2;
        tick(1);
        check("midfilter_accept", int'(data_o), 1);
`else
        pad_edge(1'b1, lat(0));
        tick(6);
        deb_len_i = 8'd2;
        check("nodeb_follow", int'(data_o), 1);
`endif
        tick(3);
        pad_edge(1'b0, lat(2));
        tick(lat(2) + 3);

        // Input enable dropping while data_o=1 gives a filtered fall.
        deb_len_i = 8'd4;
        l = lat(4);
        pad_edge(1'b1, l);
        tick(l + 3);
        k = cyc;
        cfg_ie_i  = 1'b0;
        e.is_rise = 1'b0;
        e.cyc     = k + 1 + l + 1;
        exp_q.push_back(e);
        tick(l);
        check("ie_drop_hold", int'(data_o), 1);
        tick(1);
        check("ie_drop_fall", int'(data_o), 0);
        tick(3);
        PAD_DI_I = 1'b0;
        cfg_ie_i = 1'b1;
        tick(6);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
